// File: rtl/jpeg_slot_sequencer_pkg.sv
// Shared types and elaboration helpers for the JPEG slot sequencer.
package jpeg_slot_sequencer_pkg;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_REQ  = 3'd1,
        S_RUN  = 3'd2,
        S_WAIT = 3'd3,
        S_HALT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_NEXT = 2'd1,
        CMD_BACK = 2'd2,
        CMD_HOME = 2'd3
    } cmd_t;

    // Ceiling log2, never below 1 so a width built from it is always legal.
    function automatic int log2(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Address of the last slot, built by repeated addition at elaboration.
    function automatic logic [31:0] last_addr(input logic [31:0] start,
                                              input logic [31:0] offset,
                                              input int n);
        logic [31:0] acc;
        acc = start;
        for (int i = 1; i < n; i++) begin
            acc = acc + offset;
        end
        return acc;
    endfunction

endpackage

// File: rtl/jpeg_slot_sequencer_btn_debounce.sv
// Two-flop synchroniser, stable-level debounce counter and rising-edge pulse.
module jpeg_slot_sequencer_btn_debounce #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic r_sysclk,
    input  logic r_arstn,
    input  logic i_btn,
    output logic o_rise
);

    logic [1:0]  sync_r;
    logic [15:0] cnt_r;
    logic        level_r;
    logic        rise_r;

    // Level flips only after DEB_CYCLES consecutive samples differing from it.
    always_ff @(posedge r_sysclk or negedge r_arstn) begin
        if (!r_arstn) begin
            sync_r  <= 2'b00;
            cnt_r   <= 16'd0;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], i_btn};
            rise_r <= 1'b0;
            if (sync_r[1] == level_r) begin
                cnt_r <= 16'd0;
            end else if (cnt_r == DEB_CYCLES - 16'd1) begin
                cnt_r   <= 16'd0;
                level_r <= sync_r[1];
                rise_r  <= sync_r[1];
            end else begin
                cnt_r <= cnt_r + 16'd1;
            end
        end
    end

    assign o_rise = rise_r;

endmodule

// File: rtl/jpeg_slot_sequencer.sv
// Selects the next JPEG slot in flash and handshakes decode requests.
// Optional auto-advance slideshow is enabled with the SLIDESHOW_EN macro.
module jpeg_slot_sequencer
    import jpeg_slot_sequencer_pkg::*;
#(
    parameter int                              SPI_FLASH_ADDR_WIDTH = 24,
    parameter int                              NUM_OF_JPG           = 32,
    parameter logic [SPI_FLASH_ADDR_WIDTH-1:0] START_ADDR           = 24'h100000,
    parameter logic [SPI_FLASH_ADDR_WIDTH-1:0] ADDR_OFFSET          = 24'h020000,
    parameter logic [15:0]                     DEB_CYCLES           = 16'd50000,
    parameter int                              ERR_SKIP_MAX         = 3
`ifdef SLIDESHOW_EN
    ,
    parameter logic [31:0]                     SLIDE_CYCLES         = 32'd100000000
`endif
) (
    input  logic                            r_sysclk,
    input  logic                            r_arstn,
    input  logic                            i_next,
    input  logic                            i_back,
    input  logic                            i_interrupt,
    input  logic                            i_lcd_init_done,
    output logic                            o_req,
    input  logic                            i_ack,
    input  logic                            i_done,
    input  logic                            i_err,
    output logic [SPI_FLASH_ADDR_WIDTH-1:0] o_addr,
    output logic [log2(NUM_OF_JPG)-1:0]     o_idx,
    output logic                            o_busy,
    output logic                            o_halt
);

    localparam int AW = SPI_FLASH_ADDR_WIDTH;
    localparam int IW = log2(NUM_OF_JPG);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_OF_JPG - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(last_addr(32'(START_ADDR), 32'(ADDR_OFFSET), NUM_OF_JPG));

    logic           next_rise_s, back_rise_s, home_rise_s;
    state_t         state_r, state_s;
    cmd_t           pend_r, dir_r, ev_s, cmd_s, apply_cmd_s, dir_nxt_s;
    logic           apply_s, consume_s;
    logic [7:0]     err_r, err_s;
    logic [IW-1:0]  idx_r, idx_nxt_s;
    logic [AW-1:0]  addr_r, addr_nxt_s;
    logic           req_r, busy_r, halt_r;

    jpeg_slot_sequencer_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .r_sysclk(r_sysclk), .r_arstn(r_arstn), .i_btn(i_next), .o_rise(next_rise_s));
    jpeg_slot_sequencer_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_back (
        .r_sysclk(r_sysclk), .r_arstn(r_arstn), .i_btn(i_back), .o_rise(back_rise_s));
    jpeg_slot_sequencer_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_home (
        .r_sysclk(r_sysclk), .r_arstn(r_arstn), .i_btn(i_interrupt), .o_rise(home_rise_s));

`ifdef SLIDESHOW_EN
    logic [31:0] slide_r;
    logic        slide_hit_s;
    assign slide_hit_s = (state_r == S_WAIT) && (slide_r == SLIDE_CYCLES - 32'd1);

    // Slideshow timer: counts idle time in S_WAIT, restarts on any button event.
    always_ff @(posedge r_sysclk or negedge r_arstn) begin
        if (!r_arstn) begin
            slide_r <= 32'd0;
        end else if ((state_r == S_WAIT) && (state_s == S_WAIT) && (ev_s == CMD_NONE)) begin
            slide_r <= slide_r + 32'd1;
        end else begin
            slide_r <= 32'd0;
        end
    end
`endif

    // Merge button events and pick the command that would be applied now.
    always_comb begin
        ev_s = CMD_NONE;
        if (home_rise_s) begin
            ev_s = CMD_HOME;
        end else if (next_rise_s && !back_rise_s) begin
            ev_s = CMD_NEXT;
        end else if (back_rise_s && !next_rise_s) begin
            ev_s = CMD_BACK;
        end else begin
            ev_s = CMD_NONE;
        end
        cmd_s = CMD_NONE;
        if (ev_s != CMD_NONE) begin
            cmd_s = ev_s;
        end else if (pend_r != CMD_NONE) begin
            cmd_s = pend_r;
`ifdef SLIDESHOW_EN
        end else if (slide_hit_s) begin
            cmd_s = CMD_NEXT;
`endif
        end else begin
            cmd_s = CMD_NONE;
        end
    end

    // Next-state logic; an error retries one slot further in the last direction.
    always_comb begin
        state_s     = state_r;
        apply_s     = 1'b0;
        consume_s   = 1'b0;
        apply_cmd_s = cmd_s;
        err_s       = err_r;
        case (state_r)
            S_INIT: begin
                if (i_lcd_init_done) begin
                    state_s = S_REQ;
                end else begin
                    state_s = S_INIT;
                end
            end
            S_REQ: begin
                if (i_ack) begin
                    state_s = S_RUN;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_RUN: begin
                if (i_err) begin
                    err_s = err_r + 8'd1;
                    if (err_r + 8'd1 == 8'(ERR_SKIP_MAX)) begin
                        state_s = S_HALT;
                    end else begin
                        apply_s     = 1'b1;
                        apply_cmd_s = dir_r;
                        state_s     = S_REQ;
                    end
                end else if (i_done) begin
                    err_s = 8'd0;
                    if (cmd_s != CMD_NONE) begin
                        apply_s   = 1'b1;
                        consume_s = 1'b1;
                        state_s   = S_REQ;
                    end else begin
                        state_s = S_WAIT;
                    end
                end else begin
                    state_s = S_RUN;
                end
            end
            S_WAIT, S_HALT: begin
                if (cmd_s != CMD_NONE) begin
                    err_s     = 8'd0;
                    apply_s   = 1'b1;
                    consume_s = 1'b1;
                    state_s   = S_REQ;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = S_INIT;
            end
        endcase
        if (!i_lcd_init_done) begin
            state_s   = S_INIT;
            apply_s   = 1'b0;
            consume_s = 1'b0;
            err_s     = err_r;
        end else begin
            state_s = state_s;
        end
    end

    // Slot arithmetic by increment/decrement with wrap; no multiplier needed.
    always_comb begin
        idx_nxt_s  = idx_r;
        addr_nxt_s = addr_r;
        dir_nxt_s  = dir_r;
        case (apply_cmd_s)
            CMD_NEXT: begin
                dir_nxt_s = CMD_NEXT;
                if (idx_r == LAST_IDX) begin
                    idx_nxt_s  = {IW{1'b0}};
                    addr_nxt_s = START_ADDR;
                end else begin
                    idx_nxt_s  = idx_r + IW'(1);
                    addr_nxt_s = addr_r + ADDR_OFFSET;
                end
            end
            CMD_BACK: begin
                dir_nxt_s = CMD_BACK;
                if (idx_r == {IW{1'b0}}) begin
                    idx_nxt_s  = LAST_IDX;
                    addr_nxt_s = LAST_ADDR;
                end else begin
                    idx_nxt_s  = idx_r - IW'(1);
                    addr_nxt_s = addr_r - ADDR_OFFSET;
                end
            end
            CMD_HOME: begin
                dir_nxt_s  = CMD_NEXT;
                idx_nxt_s  = {IW{1'b0}};
                addr_nxt_s = START_ADDR;
            end
            default: begin
                idx_nxt_s = idx_r;
            end
        endcase
    end

    // State, pending command, slot and registered outputs.
    always_ff @(posedge r_sysclk or negedge r_arstn) begin
        if (!r_arstn) begin
            state_r <= S_INIT;
            pend_r  <= CMD_NONE;
            dir_r   <= CMD_NEXT;
            err_r   <= 8'd0;
            idx_r   <= {IW{1'b0}};
            addr_r  <= START_ADDR;
            req_r   <= 1'b0;
            busy_r  <= 1'b0;
            halt_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            err_r   <= err_s;
            if (consume_s) begin
                pend_r <= CMD_NONE;
            end else if (ev_s != CMD_NONE) begin
                pend_r <= ev_s;
            end else begin
                pend_r <= pend_r;
            end
            if (apply_s) begin
                idx_r  <= idx_nxt_s;
                addr_r <= addr_nxt_s;
                dir_r  <= dir_nxt_s;
            end else begin
                idx_r  <= idx_r;
            end
            req_r  <= (state_s == S_REQ);
            busy_r <= (state_s == S_REQ) || (state_s == S_RUN);
            halt_r <= (state_s == S_HALT);
        end
    end

    assign o_req  = req_r;
    assign o_busy = busy_r;
    assign o_halt = halt_r;
    assign o_addr = addr_r;
    assign o_idx  = idx_r;

endmodule

// File: tb/tb_jpeg_slot_sequencer.sv
// Directed plus randomized bench for jpeg_slot_sequencer with a slot-number model.
module tb_jpeg_slot_sequencer;

    localparam int          N     = 4;
    localparam logic [23:0] START = 24'h100000;
    localparam logic [23:0] OFF   = 24'h020000;

    logic        clk, rst_n;
    logic        nxt, bck, intr, lcd, ack, done, err;
    logic        req, busy, halt;
    logic [23:0] addr;
    logic [1:0]  idx;

    int checks   = 0;
    int failures = 0;
    int m_idx    = 0;
    int m_dir    = 1;

    jpeg_slot_sequencer #(
        .NUM_OF_JPG(N), .START_ADDR(START), .ADDR_OFFSET(OFF),
        .DEB_CYCLES(16'd4), .ERR_SKIP_MAX(3)
    ) dut (
        .r_sysclk(clk), .r_arstn(rst_n), .i_next(nxt), .i_back(bck),
        .i_interrupt(intr), .i_lcd_init_done(lcd), .o_req(req), .i_ack(ack),
        .i_done(done), .i_err(err), .o_addr(addr), .o_idx(idx),
        .o_busy(busy), .o_halt(halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_addr();
        return 24'(START + OFF * 24'(m_idx));
    endfunction

    // 0=next 1=back 2=home
    task automatic model_cmd(input int c);
        if (c == 0) begin m_idx = (m_idx + 1) % N; m_dir = 1; end
        else if (c == 1) begin m_idx = (m_idx + N - 1) % N; m_dir = -1; end
        else begin m_idx = 0; m_dir = 1; end
    endtask

    // 0=next 1=back 2=home 3=next+back together
    task automatic press(input int which);
        int hold;
        hold = 6 + int'($urandom_range(0, 4));
        nxt  = (which == 0) || (which == 3);
        bck  = (which == 1) || (which == 3);
        intr = (which == 2);
        repeat (hold) tick();
        nxt = 1'b0; bck = 1'b0; intr = 1'b0;
        repeat (10) tick();
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 60 && req !== 1'b1; i++) tick();
        check({tag, "_req"}, 32'(req), 32'd1);
        check({tag, "_addr"}, 32'(addr), 32'(exp_addr()));
        check({tag, "_idx"}, 32'(idx), 32'(m_idx));
    endtask

    task automatic do_ack(input string tag);
        repeat ($urandom_range(0, 3)) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, "_req_drop"}, 32'(req), 32'd0);
        check({tag, "_busy_run"}, 32'(busy), 32'd1);
    endtask

    task automatic do_done(input string tag);
        repeat ($urandom_range(1, 5)) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_err();
        err = 1'b1;
        tick();
        err = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; nxt = 1'b0; bck = 1'b0; intr = 1'b0;
        lcd = 1'b0; ack = 1'b0; done = 1'b0; err = 1'b0;
        repeat (3) tick();
        check("rst_req", 32'(req), 32'd0);
        check("rst_addr", 32'(addr), 32'(START));
        check("rst_idx", 32'(idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halt", 32'(halt), 32'd0);
        rst_n = 1'b1;

        // 1: init gating, first request one cycle after init done
        repeat (20) tick();
        check("init_hold_req", 32'(req), 32'd0);
        lcd = 1'b1;
        tick();
        check("init_req", 32'(req), 32'd1);
        wait_req("first");
        do_ack("first");
        do_done("first");

        // 2: four NEXT presses with wrap
        for (int k = 0; k < 4; k++) begin
            press(0);
            model_cmd(0);
            wait_req("next");
            do_ack("next");
            do_done("next");
        end

        // 3: BACK wrap at idx 0, then a short glitch
        press(1);
        model_cmd(1);
        wait_req("back_wrap");
        do_ack("back_wrap");
        do_done("back_wrap");
        nxt = 1'b1;
        repeat (2) tick();
        nxt = 1'b0;
        repeat (15) tick();
        check("glitch_noreq", 32'(req), 32'd0);

        // 4: NEXT during RUN is held until done
        press(0);
        model_cmd(0);
        wait_req("pre_run");
        do_ack("pre_run");
        press(0);
        model_cmd(0);
        check("run_hold_req", 32'(req), 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("pend_req_1cyc", 32'(req), 32'd1);
        wait_req("pend");
        do_ack("pend");
        do_done("pend");
        press(3);
        check("cancel_noreq", 32'(req), 32'd0);

        // 5: error skipping to halt, HOME recovers
        press(2);
        model_cmd(2);
        wait_req("home");
        do_ack("home");
        for (int k = 0; k < 2; k++) begin
            pulse_err();
            m_idx = (m_idx + N + m_dir) % N;
            wait_req("skip");
            do_ack("skip");
        end
        pulse_err();
        check("halt_set", 32'(halt), 32'd1);
        check("halt_req", 32'(req), 32'd0);
        repeat (5) tick();
        check("halt_busy", 32'(busy), 32'd0);
        press(2);
        model_cmd(2);
        check("halt_clear", 32'(halt), 32'd0);
        wait_req("halt_home");
        do_ack("halt_home");
        do_done("halt_home");

        // 6: LCD init drop while requesting, same slot re-requested
        press(0);
        model_cmd(0);
        wait_req("pre_drop");
        lcd = 1'b0;
        tick();
        check("drop_req", 32'(req), 32'd0);
        repeat (5) tick();
        check("drop_busy", 32'(busy), 32'd0);
        lcd = 1'b1;
        tick();
        check("reinit_req", 32'(req), 32'd1);
        wait_req("reinit");
        do_ack("reinit");
        do_done("reinit");

        // randomized command sequence against the slot model
        for (int k = 0; k < 8; k++) begin
            int c;
            c = int'($urandom_range(0, 2));
            press(c);
            model_cmd(c);
            wait_req("rand");
            do_ack("rand");
            do_done("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
